// File: rtl/ks_pluck_feeder.sv
// Karplus-Strong pluck feeder: LFSR noise burst on pluck, then averaging feedback ring.
// Optional decay stage enabled by defining KS_DECAY_EN.
module ks_pluck_feeder #(
  parameter int          WIDTH    = 8,
  parameter int          LEN_W    = 8,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          DECAY_SH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pluck,
  input  logic             mute,
  input  logic [LEN_W-1:0] burst_len,
  input  logic [WIDTH-1:0] fb_in,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             ringing
);

  typedef enum logic [1:0] {IDLE, BURST, RING} state_t;

  state_t           state_reg;
  logic [15:0]      lfsr_reg;
  logic [15:0]      lfsr_next;
  logic [LEN_W-1:0] cnt_reg;
  logic [LEN_W-1:0] cnt_load;
  logic [WIDTH-1:0] prev_fb_reg;
  logic [WIDTH-1:0] out_reg;
  logic             busy_reg;
  logic             ringing_reg;
  logic [WIDTH-1:0] noise;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] avg;
  logic [WIDTH-1:0] ring_sample;

  if (WIDTH > 16 || WIDTH < 1 || SEED == 16'h0000 || DECAY_SH < 0) begin : g_bad_cfg
    $error("ks_pluck_feeder: invalid parameter set");
  end

  assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
  assign noise     = lfsr_reg[15 -: WIDTH];
  // One extra bit so the two-sample average never wraps.
  assign sum       = {1'b0, fb_in} + {1'b0, prev_fb_reg};
  assign avg       = WIDTH'(sum >> 1);
  assign cnt_load  = (burst_len == '0) ? '0 : burst_len - 1'b1;

`ifdef KS_DECAY_EN
  assign ring_sample = avg - (avg >> DECAY_SH);
`else
  assign ring_sample = avg;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      lfsr_reg    <= SEED;
      cnt_reg     <= '0;
      prev_fb_reg <= '0;
      out_reg     <= '0;
      busy_reg    <= 1'b0;
      ringing_reg <= 1'b0;
    end else begin
      prev_fb_reg <= fb_in;
      if (mute) begin
        state_reg   <= IDLE;
        out_reg     <= '0;
        busy_reg    <= 1'b0;
        ringing_reg <= 1'b0;
      end else if (pluck) begin
        // The LFSR is never reseeded here, so each pluck gets fresh noise.
        state_reg   <= BURST;
        cnt_reg     <= cnt_load;
        out_reg     <= noise;
        lfsr_reg    <= lfsr_next;
        busy_reg    <= 1'b1;
        ringing_reg <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            out_reg <= '0;
          end
          BURST: begin
            if (cnt_reg != '0) begin
              cnt_reg  <= cnt_reg - 1'b1;
              out_reg  <= noise;
              lfsr_reg <= lfsr_next;
            end else begin
              state_reg   <= RING;
              busy_reg    <= 1'b0;
              ringing_reg <= 1'b1;
              out_reg     <= ring_sample;
            end
          end
          RING: begin
            out_reg <= ring_sample;
          end
          default: begin
            state_reg   <= IDLE;
            out_reg     <= '0;
            busy_reg    <= 1'b0;
            ringing_reg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out     = out_reg;
  assign busy    = busy_reg;
  assign ringing = ringing_reg;

endmodule

// File: tb/tb_ks_pluck_feeder.sv
// Randomised self-checking bench for ks_pluck_feeder against a behavioural model.
module tb_ks_pluck_feeder;

  localparam int          WIDTH = 8;
  localparam int          LEN_W = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk;
  logic             rst;
  logic             pluck;
  logic             mute;
  logic [LEN_W-1:0] burst_len;
  logic [WIDTH-1:0] fb_in;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             ringing;

  int n_total = 0;
  int n_pass  = 0;

  ks_pluck_feeder #(.WIDTH(WIDTH), .LEN_W(LEN_W), .SEED(SEED), .DECAY_SH(7)) dut (
    .clk(clk), .rst(rst), .pluck(pluck), .mute(mute), .burst_len(burst_len),
    .fb_in(fb_in), .out(out), .busy(busy), .ringing(ringing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // n-th value of the noise register counting from the seed.
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] q;
    q = SEED;
    for (int i = 0; i < n; i++) q = {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    return q;
  endfunction

  function automatic int ring_of(input int a, input int b);
    int avg;
    avg = (a + b) / 2;
`ifdef KS_DECAY_EN
    avg = avg - avg / 128;
`endif
    return avg;
  endfunction

  // Model: mode 0 silent, 1 noise burst, 2 ringing; m_idx counts noise samples since reset.
  int   m_mode, m_left, m_idx, m_prev;
  int   exp_out;
  bit   exp_busy, exp_ring, m_valid;

  initial begin
    m_valid = 0; m_mode = 0; m_left = 0; m_idx = 0; m_prev = 0;
    exp_out = 0; exp_busy = 0; exp_ring = 0;
    forever begin
      logic [15:0] q;
      int noise_v, ring_v, len;
      @(posedge clk);
      q = lfsr_at(m_idx);
      noise_v = int'(q >> 8);
      ring_v = ring_of(int'(fb_in), m_prev);
      if (rst) begin
        m_valid = 1; m_mode = 0; m_left = 0; m_idx = 0; m_prev = 0;
        exp_out = 0; exp_busy = 0; exp_ring = 0;
      end else begin
        if (mute) begin
          m_mode = 0; exp_out = 0; exp_busy = 0; exp_ring = 0;
        end else if (pluck) begin
          len = (burst_len == 0) ? 1 : int'(burst_len);
          m_mode = 1; m_left = len - 1; exp_out = noise_v; m_idx++;
          exp_busy = 1; exp_ring = 0;
        end else if (m_mode == 1 && m_left > 0) begin
          m_left--; exp_out = noise_v; m_idx++;
        end else if (m_mode != 0) begin
          m_mode = 2; exp_out = ring_v; exp_busy = 0; exp_ring = 1;
        end else begin
          exp_out = 0;
        end
        m_prev = int'(fb_in);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check("out", int'(out), exp_out);
        check("busy", int'(busy), int'(exp_busy));
        check("ringing", int'(ringing), int'(exp_ring));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst = 1; pluck = 0; mute = 0; burst_len = 0; fb_in = 8'hFF;
    step(); step();
    check("rst_out", int'(out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ringing", int'(ringing), 0);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("idle_out", int'(out), 0);
    end

    pluck = 1; burst_len = 4; step(); pluck = 0;
    check("b4_n0", int'(out), 8'hAC); check("b4_busy0", int'(busy), 1);
    step(); check("b4_n1", int'(out), 8'h59);
    step(); check("b4_n2", int'(out), 8'hB3);
    step(); check("b4_n3", int'(out), 8'h67); check("b4_busy3", int'(busy), 1);
    step(); check("b4_end_busy", int'(busy), 0); check("b4_end_ring", int'(ringing), 1);

    fb_in = 100; step(); step(); check("ring_100", int'(out), 100);
    fb_in = 101; step(); check("ring_avg", int'(out), 100);
    step(); check("ring_101", int'(out), 101);
    fb_in = 200; step(); step(); step();
`ifdef KS_DECAY_EN
    check("ring_200_decay", int'(out), 199);
`else
    check("ring_200", int'(out), 200);
`endif

    rst = 1; step(); rst = 0;
    pluck = 1; burst_len = 0; step(); pluck = 0;
    check("b0_noise", int'(out), 8'hAC); check("b0_busy", int'(busy), 1);
    step(); check("b0_busy_off", int'(busy), 0); check("b0_ring", int'(ringing), 1);

    pluck = 1; mute = 1; step(); pluck = 0; mute = 0;
    check("mute_out", int'(out), 0); check("mute_ring", int'(ringing), 0);
    step();
    pluck = 1; burst_len = 2; step(); pluck = 0;
    check("cont_n0", int'(out), 8'h59);
    step(); check("cont_n1", int'(out), 8'hB3);
    step(); check("cont_ring", int'(ringing), 1);

    pluck = 1; burst_len = 8; step(); pluck = 0;
    rst = 1; step(); rst = 0;
    check("midrst_out", int'(out), 0); check("midrst_busy", int'(busy), 0);
    pluck = 1; burst_len = 1; step(); pluck = 0;
    check("reseed_n0", int'(out), 8'hAC);
    step(); check("reseed_ring", int'(ringing), 1);

    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      mute  = ($urandom_range(0, 49) == 0);
      pluck = ($urandom_range(0, 24) == 0);
      burst_len = ($urandom_range(0, 3) == 0) ? LEN_W'($urandom_range(0, 255))
                                              : LEN_W'($urandom_range(0, 12));
      fb_in = WIDTH'($urandom);
      step();
    end
    rst = 0; mute = 0; pluck = 0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
